// File: rtl/axi_pkg.sv
// AXI4-Lite shared definitions: response encodings and a helper that
// folds a two-bit response code into a single error flag.
package axi_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // OKAY and EXOKAY are successful; SLVERR and DECERR are both reported
    // to the register side as a plain error.
    function automatic logic resp_is_error(input resp_t resp);
        logic is_err;
        case (resp)
            RESP_OKAY, RESP_EXOKAY:   is_err = 1'b0;
            RESP_SLVERR, RESP_DECERR: is_err = 1'b1;
            default:                  is_err = 1'b0;
        endcase
        return is_err;
    endfunction

endpackage

// File: rtl/reg_to_axi_lite.sv
// Register-interface target to AXI4-Lite manager bridge.
//
// A single reg-bus request is accepted in IDLE, its address/data/strobes are
// captured, and the matching AXI-Lite transaction is issued from those
// registers. Exactly one transaction is in flight at a time. The reg side sees
// a one-cycle reg_ready_o pulse in the cycle the B or R response is taken.
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   reg_valid_i .. reg_wstrb_i      reg-bus request (held until reg_ready_o)
//   reg_ready_o, reg_rdata_o,
//   reg_error_o                     reg-bus completion pulse and response
//   aw_*, w_*, b_*                  AXI-Lite write channels
//   ar_*, r_*                       AXI-Lite read channels
module reg_to_axi_lite
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  AXI_PROT   = 3'b000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // reg-bus target
    input  logic                    reg_valid_i,
    input  logic                    reg_write_i,
    input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
    output logic                    reg_ready_o,
    output logic [DATA_WIDTH-1:0]   reg_rdata_o,
    output logic                    reg_error_o,
    // AXI-Lite AW
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [2:0]              aw_prot_o,
    // AXI-Lite W
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    // AXI-Lite B
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [1:0]              b_resp_i,
    // AXI-Lite AR
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [2:0]              ar_prot_o,
    // AXI-Lite R
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRITE_RESP,
        ST_READ,
        ST_READ_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;

    // Payloads come straight from the capture registers, so they cannot move
    // while a valid is pending.
    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign aw_prot_o = AXI_PROT;
    assign ar_prot_o = AXI_PROT;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = wstrb_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;
        reg_ready_o = 1'b0;
        reg_rdata_o = '0;
        reg_error_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (reg_valid_i) begin
                    addr_d  = reg_addr_i;
                    wdata_d = reg_wdata_i;
                    wstrb_d = reg_wstrb_i;
                    state_d = reg_write_i ? ST_WRITE : ST_READ;
                end
            end

            ST_WRITE: begin
                // AW and W are independent; each valid drops once its own
                // handshake is recorded, and the pair may finish in any order.
                aw_valid_o = !aw_done_q;
                w_valid_o  = !w_done_q;
                aw_done_d  = aw_done_q | aw_ready_i;
                w_done_d   = w_done_q  | w_ready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WRITE_RESP;
                end
            end

            ST_WRITE_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    reg_ready_o = 1'b1;
                    reg_error_o = resp_is_error(b_resp_i);
                    state_d     = ST_IDLE;
                end
            end

            ST_READ: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    state_d = ST_READ_RESP;
                end
            end

            ST_READ_RESP: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    reg_ready_o = 1'b1;
                    reg_rdata_o = r_data_i;
                    reg_error_o = resp_is_error(r_resp_i);
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of process order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

`ifndef SYNTHESIS
    // The initiator must hold its request until the completion pulse; the
    // bridge finishes the AXI transaction regardless, this only flags misuse.
    reg_valid_held : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q != ST_IDLE) |-> reg_valid_i
    );
`endif

endmodule
